// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_if
//  Purpose  : Operand-side and result-side valid/ready bundle for seq_alu.
//             master = decode/control side, slave = the ALU itself.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             cout;
    logic             overflow;
    logic             div_zero;
    logic             illegal;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, zero, negative, cout, overflow,
               div_zero, illegal
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, zero, negative, cout, overflow,
               div_zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Registered ALU with valid/ready handshakes. Logic/arith/shift
//             ops finish in one cycle; MUL/DIVU/REMU iterate one bit per
//             cycle through a shared hi/lo register pair.
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH         = 32,
    parameter bit SUB_MAGNITUDE = 1'b0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    seq_alu_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_started;
    logic [3:0]       r_sel;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;   // MUL: upper product half; DIV: partial remainder
    logic [WIDTH-1:0] r_lo;   // MUL: multiplier/low product; DIV: dividend/quotient
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_neg, r_cout, r_ovf, r_divz, r_ill;

    logic             w_accept;
    logic             w_iter_op;
    logic             w_last;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_iter_op = (bus.sel == OP_MUL) ||
                       (((bus.sel == OP_DIVU) || (bus.sel == OP_REMU)) && (bus.b != '0));
    assign w_last    = (r_cnt == SHW'(WIDTH - 1));

    // in_ready is held low through reset and the first clock after release
    assign bus.in_ready  = r_started && (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_neg;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
    assign bus.div_zero  = r_divz;
    assign bus.illegal   = r_ill;

    // Single-cycle result and flags, computed straight from the presented operands
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_res;
    logic [SHW-1:0]   w_shamt;
    logic             w_cout, w_ovf, w_neg, w_mag, w_divz, w_ill;
    always_comb begin
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
        w_shamt = bus.b[SHW-1:0];
        w_res   = '0;
        w_cout  = 1'b0;
        w_ovf   = 1'b0;
        w_mag   = 1'b0;
        w_divz  = 1'b0;
        w_ill   = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                if (SUB_MAGNITUDE) begin
                    w_mag = 1'b1;
                    w_res = w_diff[WIDTH] ? (bus.b - bus.a) : w_diff[WIDTH-1:0];
                end else begin
                    w_res  = w_diff[WIDTH-1:0];
                    w_cout = w_diff[WIDTH];
                    w_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
                end
            end
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_SLL:  w_res = bus.a << w_shamt;
            OP_SRL:  w_res = bus.a >> w_shamt;
            OP_SRA:  w_res = WIDTH'($signed(bus.a) >>> w_shamt);
            OP_MUL:  w_res = '0;
            // Only reach the register when b==0; nonzero divisors iterate
            OP_DIVU: begin w_res = '1;    w_divz = 1'b1; end
            OP_REMU: begin w_res = bus.a; w_divz = 1'b1; end
            default: w_ill = 1'b1;
        endcase
        // Magnitude SUB reports the sign of the true difference, not of |a-b|
        w_neg = w_mag ? w_diff[WIDTH] : w_res[WIDTH-1];
    end

    // One shift-add (MUL) or one restoring step (DIVU/REMU) per cycle
    logic [WIDTH:0]   w_msum, w_shift, w_trial;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt, w_fin;
    logic             w_fin_ovf;
    always_comb begin
        w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_b};
        if (r_sel == OP_MUL) begin
            w_hi_nxt = w_msum[WIDTH:1];
            w_lo_nxt = {w_msum[0], r_lo[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            w_hi_nxt = w_trial[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            // Trial went negative, so the shifted remainder still fits in WIDTH bits
            w_hi_nxt = w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
        end
        w_fin     = (r_sel == OP_REMU) ? w_hi_nxt : w_lo_nxt;
        w_fin_ovf = (r_sel == OP_MUL) && (w_hi_nxt != '0);
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_iter_op ? S_BUSY : S_DONE;
            S_BUSY:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers and the registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_divz   <= 1'b0;
            r_ill    <= 1'b0;
        end else if (w_accept) begin
            r_sel <= bus.sel;
            r_b   <= bus.b;
            r_hi  <= '0;
            r_lo  <= bus.a;
            r_cnt <= '0;
            if (w_iter_op) begin
                r_zero <= 1'b0;
                r_neg  <= 1'b0;
                r_cout <= 1'b0;
                r_ovf  <= 1'b0;
                r_divz <= 1'b0;
                r_ill  <= 1'b0;
            end else begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_neg    <= w_neg;
                r_cout   <= w_cout;
                r_ovf    <= w_ovf;
                r_divz   <= w_divz;
                r_ill    <= w_ill;
            end
        end else if (r_state == S_BUSY) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + SHW'(1);
            if (w_last) begin
                r_result <= w_fin;
                r_zero   <= (w_fin == '0);
                r_neg    <= w_fin[WIDTH-1];
                r_ovf    <= w_fin_ovf;
            end
        end
    end
endmodule
`default_nettype wire
